// File: rtl/vga_draw_sprites.sv
// Sprite compositor: overlays N_SPR ROM-backed sprites on an incoming VGA
// pixel stream, with colour-key transparency and per-frame overlap detection.
module vga_draw_sprites #(
  parameter int          N_SPR     = 2,
  parameter int          SPR_W     = 16,
  parameter int          SPR_H     = 16,
  parameter int          ROM_LAT   = 1,
  parameter logic [11:0] KEY_COLOR = 12'hF0F,
  localparam int         WB        = $clog2(SPR_W),
  localparam int         HB        = $clog2(SPR_H),
  localparam int         AW        = WB + HB
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic [10:0]           hcount_in,
  input  logic [10:0]           vcount_in,
  input  logic                  hsync_in,
  input  logic                  hblnk_in,
  input  logic                  vsync_in,
  input  logic                  vblnk_in,
  input  logic [11:0]           rgb_in,
  input  logic [N_SPR*12-1:0]   xpos,
  input  logic [N_SPR*12-1:0]   ypos,
  input  logic [N_SPR-1:0]      en,
  input  logic [N_SPR*12-1:0]   rgb_pixel,
  output logic [10:0]           hcount_out,
  output logic [10:0]           vcount_out,
  output logic                  hsync_out,
  output logic                  hblnk_out,
  output logic                  vsync_out,
  output logic                  vblnk_out,
  output logic [11:0]           rgb_out,
  output logic [N_SPR*AW-1:0]   pixel_addr,
  output logic                  collision
);

  localparam int PW = N_SPR + 11 + 11 + 4 + 12;

  // Shadow copies of the sprite controls, refreshed only at the start of
  // vertical blanking so a sprite never moves halfway down the screen.
  logic              vblnk_prev_q;
  logic [11:0]       xs_q [N_SPR];
  logic [11:0]       ys_q [N_SPR];
  logic [N_SPR-1:0]  ens_q;
  logic              load_shadow;

  assign load_shadow = vblnk_in & ~vblnk_prev_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      ens_q        <= '0;
      for (int k = 0; k < N_SPR; k++) begin
        xs_q[k] <= '0;
        ys_q[k] <= '0;
      end
    end else begin
      vblnk_prev_q <= vblnk_in;
      if (load_shadow) begin
        ens_q <= en;
        for (int k = 0; k < N_SPR; k++) begin
          xs_q[k] <= xpos[k*12 +: 12];
          ys_q[k] <= ypos[k*12 +: 12];
        end
      end
    end
  end

  // Stage 1: hit test and ROM address. Everything is widened to 13 bits so
  // x+SPR_W never wraps, which clips sprites hanging off the right/bottom.
  logic [12:0]       h13, v13;
  logic [N_SPR-1:0]  inside_d;
  logic [N_SPR*AW-1:0] addr_d;

  assign h13 = {2'b00, hcount_in};
  assign v13 = {2'b00, vcount_in};

  always_comb begin
    inside_d = '0;
    addr_d   = '0;
    for (int k = 0; k < N_SPR; k++) begin
      inside_d[k] = ens_q[k]
                  & (xs_q[k][11:10] == 2'b00) & (ys_q[k][11:10] == 2'b00)
                  & (h13 >= {1'b0, xs_q[k]}) & (h13 < {1'b0, xs_q[k]} + 13'(SPR_W))
                  & (v13 >= {1'b0, ys_q[k]}) & (v13 < {1'b0, ys_q[k]} + 13'(SPR_H));
      addr_d[k*AW +: AW] = {HB'(v13 - {1'b0, ys_q[k]}), WB'(h13 - {1'b0, xs_q[k]})};
    end
  end

  // Stage 1 register followed by ROM_LAT delay slots so the flags, timing and
  // background line up with the ROM data coming back.
  logic [PW-1:0] pipe_q [ROM_LAT+1];
  logic [N_SPR*AW-1:0] addr_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      addr_q <= '0;
      for (int i = 0; i <= ROM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      addr_q    <= addr_d;
      pipe_q[0] <= {inside_d, hcount_in, vcount_in, hsync_in, hblnk_in,
                    vsync_in, vblnk_in, rgb_in};
      for (int i = 1; i <= ROM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign pixel_addr = addr_q;

  logic [N_SPR-1:0] al_inside;
  logic [10:0]      al_h, al_v;
  logic             al_hs, al_hb, al_vs, al_vb;
  logic [11:0]      al_rgb;

  assign {al_inside, al_h, al_v, al_hs, al_hb, al_vs, al_vb, al_rgb} = pipe_q[ROM_LAT];

  // Composite: lowest channel index has priority, blanking forces black.
  logic [N_SPR-1:0] opaque;
  logic [2:0]       n_opaque;
  logic [11:0]      rgb_d;
  logic             multi_hit;

  always_comb begin
    opaque   = '0;
    n_opaque = '0;
    rgb_d    = al_rgb;
    for (int k = 0; k < N_SPR; k++) begin
      opaque[k] = al_inside[k] & (rgb_pixel[k*12 +: 12] != KEY_COLOR);
      n_opaque  = n_opaque + {2'b00, opaque[k]};
    end
    for (int k = N_SPR - 1; k >= 0; k--) begin
      if (opaque[k]) rgb_d = rgb_pixel[k*12 +: 12];
    end
    if (al_hb | al_vb) rgb_d = 12'h000;
    multi_hit = (n_opaque >= 3'd2) & ~(al_hb | al_vb);
  end

  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, hblnk_q, vsync_q, vblnk_q;
  logic [11:0] rgb_q;
  logic        coll_acc_q, collision_q;

  // collision is latched on the same edge that raises vblnk_out.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      hsync_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      vsync_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      rgb_q       <= '0;
      coll_acc_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      hcount_q <= al_h;
      vcount_q <= al_v;
      hsync_q  <= al_hs;
      hblnk_q  <= al_hb;
      vsync_q  <= al_vs;
      vblnk_q  <= al_vb;
      rgb_q    <= rgb_d;
      if (al_vb & ~vblnk_q) begin
        collision_q <= coll_acc_q;
        coll_acc_q  <= 1'b0;
      end else if (multi_hit) begin
        coll_acc_q <= 1'b1;
      end
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hsync_out  = hsync_q;
  assign hblnk_out  = hblnk_q;
  assign vsync_out  = vsync_q;
  assign vblnk_out  = vblnk_q;
  assign rgb_out    = rgb_q;
  assign collision  = collision_q;

endmodule
